// File: rtl/sic1_sequencer_if.sv
// Memory bus and program-load handshake between the SIC-1 sequencer and its byte memory.
// The sequencer is the only master; the memory/loader side takes the slave view.
interface sic1_sequencer_if;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic [7:0] mem_addr;
    logic       mem_wr_en;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata;

    modport master (
        input  load_valid,
        input  load_data,
        input  mem_rdata,
        output load_ready,
        output mem_addr,
        output mem_wr_en,
        output mem_wdata
    );

    modport slave (
        output load_valid,
        output load_data,
        output mem_rdata,
        input  load_ready,
        input  mem_addr,
        input  mem_wr_en,
        input  mem_wdata
    );
endinterface

// File: rtl/sic1_sequencer.sv
// SIC-1 subleq execution controller: loads a program byte-serially into RAM, then runs
// subleq instructions with one memory access per cycle until a branch targets 255.
module sic1_sequencer (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    sic1_sequencer_if.master         bus,
    output logic [7:0]               pc,
    output logic                     running,
    output logic                     halted
);

    localparam logic [7:0] ADDR_LOAD_MAX = 8'd252;
    localparam logic [7:0] ADDR_HALT     = 8'd255;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_A,
        S_FETCH_B,
        S_FETCH_C,
        S_READ_A,
        S_READ_B,
        S_WRITE,
        S_HALT
    } state_t;

    state_t     state, state_next;
    logic [7:0] pc_q, pc_next;
    logic [7:0] load_ptr, load_ptr_next;
    logic [7:0] a, a_next;
    logic [7:0] b, b_next;
    logic [7:0] c, c_next;
    logic [7:0] va, va_next;
    logic [7:0] vb, vb_next;

    logic [7:0] diff;
    logic       branch_taken;
    logic [7:0] target_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pc_q     <= '0;
            load_ptr <= '0;
            a        <= '0;
            b        <= '0;
            c        <= '0;
            va       <= '0;
            vb       <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values together.
            state    <= state_next;
            pc_q     <= pc_next;
            load_ptr <= load_ptr_next;
            a        <= a_next;
            b        <= b_next;
            c        <= c_next;
            va       <= va_next;
            vb       <= vb_next;
        end
    end

    // Subleq: mem[a] -= mem[b]; branch to c when the result is signed <= 0.
    assign diff         = va - vb;
    assign branch_taken = (diff == 8'd0) || diff[7];
    assign target_pc    = branch_taken ? c : pc_q + 8'd3;

    always_comb begin
        // NOTE: every output and next-state value is defaulted first so no latch is inferred.
        state_next     = state;
        pc_next        = pc_q;
        load_ptr_next  = load_ptr;
        a_next         = a;
        b_next         = b;
        c_next         = c;
        va_next        = va;
        vb_next        = vb;
        bus.mem_addr   = '0;
        bus.mem_wr_en  = 1'b0;
        bus.mem_wdata  = '0;
        bus.load_ready = 1'b0;

        case (state)
            S_IDLE: begin
                bus.load_ready = !start && (load_ptr <= ADDR_LOAD_MAX);
                if (start) begin
                    pc_next    = '0;
                    state_next = S_FETCH_A;
                end else if (bus.load_valid && bus.load_ready) begin
                    bus.mem_addr  = load_ptr;
                    bus.mem_wdata = bus.load_data;
                    bus.mem_wr_en = !rst;
                    load_ptr_next = load_ptr + 8'd1;
                end
            end
            S_FETCH_A: begin
                bus.mem_addr = pc_q;
                a_next       = bus.mem_rdata;
                state_next   = S_FETCH_B;
            end
            S_FETCH_B: begin
                bus.mem_addr = pc_q + 8'd1;
                b_next       = bus.mem_rdata;
                state_next   = S_FETCH_C;
            end
            S_FETCH_C: begin
                bus.mem_addr = pc_q + 8'd2;
                c_next       = bus.mem_rdata;
                state_next   = S_READ_A;
            end
            S_READ_A: begin
                bus.mem_addr = a;
                va_next      = bus.mem_rdata;
                state_next   = S_READ_B;
            end
            S_READ_B: begin
                bus.mem_addr = b;
                vb_next      = bus.mem_rdata;
                state_next   = S_WRITE;
            end
            S_WRITE: begin
                // Writes to 253/255 are still issued; the memory decides what to keep.
                bus.mem_addr  = a;
                bus.mem_wdata = diff;
                bus.mem_wr_en = !rst;
                pc_next       = target_pc;
                state_next    = (target_pc == ADDR_HALT) ? S_HALT : S_FETCH_A;
            end
            S_HALT: begin
                if (start) begin
                    pc_next    = '0;
                    state_next = S_FETCH_A;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign pc      = pc_q;
    assign running = (state == S_FETCH_A) || (state == S_FETCH_B) || (state == S_FETCH_C) ||
                     (state == S_READ_A)  || (state == S_READ_B)  || (state == S_WRITE);
    assign halted  = (state == S_HALT);

endmodule

// File: tb/tb_sic1_sequencer.sv
// Self-checking bench for sic1_sequencer: vector table for load/run timing, plus
// hand-written sequences for multi-instruction programs, reset abort and load overflow.
module tb_sic1_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pc;
    logic       running;
    logic       halted;

    logic [7:0] ram [0:255];
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    int         wr_count = 0;

    int passed = 0;
    int total  = 0;

    sic1_sequencer_if bus();

    sic1_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .bus     (bus.master),
        .pc      (pc),
        .running (running),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    // Memory model: 253 RAM bytes, input port at 253, output port at 254, 255 reads 0.
    assign bus.mem_rdata = (bus.mem_addr < 8'd253) ? ram[bus.mem_addr] :
                           (bus.mem_addr == 8'd253) ? ui_in : 8'h00;

    always @(posedge clk) begin
        if (bus.mem_wr_en) begin
            wr_count <= wr_count + 1;
            if (bus.mem_addr < 8'd253) ram[bus.mem_addr] <= bus.mem_wdata;
            else if (bus.mem_addr == 8'd254) uo_out <= bus.mem_wdata;
        end
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       rst;
        logic       lv;
        logic [7:0] ld;
        logic       st;
        logic       rdy;
        logic [7:0] addr;
        logic       we;
        logic [7:0] wd;
        logic       run;
        logic       hlt;
        logic [7:0] pc;
    } vec_t;

    function automatic vec_t mk(logic r, logic lv, logic [7:0] ld, logic st, logic rdy,
                                logic [7:0] addr, logic we, logic [7:0] wd,
                                logic run, logic hlt, logic [7:0] p);
        vec_t v;
        v.rst = r; v.lv = lv; v.ld = ld; v.st = st; v.rdy = rdy; v.addr = addr;
        v.we = we; v.wd = wd; v.run = run; v.hlt = hlt; v.pc = p;
        return v;
    endfunction

    // Steps one subleq instruction from FETCH_A, checking every access, then the new pc.
    task automatic run_instr(input logic [7:0] ipc, input logic [7:0] ia, input logic [7:0] ib,
                             input logic [7:0] wd, input logic [7:0] npc);
        logic [7:0] exp_addr [0:5];
        exp_addr[0] = ipc;
        exp_addr[1] = ipc + 8'd1;
        exp_addr[2] = ipc + 8'd2;
        exp_addr[3] = ia;
        exp_addr[4] = ib;
        exp_addr[5] = ia;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("pc%0h c%0d addr", ipc, k), {8'h0, bus.mem_addr}, {8'h0, exp_addr[k]});
            check($sformatf("pc%0h c%0d we", ipc, k), {15'h0, bus.mem_wr_en}, {15'h0, (k == 5)});
            check($sformatf("pc%0h c%0d run", ipc, k), {15'h0, running}, 16'h1);
            if (k == 5) check($sformatf("pc%0h wdata", ipc), {8'h0, bus.mem_wdata}, {8'h0, wd});
            step();
        end
        check($sformatf("pc%0h next_pc", ipc), {8'h0, pc}, {8'h0, npc});
    endtask

    vec_t vt [0:17];
    logic [7:0] prog [0:24];
    int wr_base;

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        uo_out         = 8'h00;
        ui_in          = 8'd5;
        rst            = 1'b1;
        start          = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;

        //            rst lv ld     st rdy addr   we wd     run hlt pc
        vt[0]  = mk(0, 0, 8'h00, 0, 1, 8'h00, 0, 8'h00, 0, 0, 8'h00);
        vt[1]  = mk(0, 1, 8'h11, 0, 1, 8'h00, 1, 8'h11, 0, 0, 8'h00);
        vt[2]  = mk(0, 1, 8'h22, 0, 1, 8'h01, 1, 8'h22, 0, 0, 8'h00);
        vt[3]  = mk(0, 1, 8'h33, 0, 1, 8'h02, 1, 8'h33, 0, 0, 8'h00);
        vt[4]  = mk(0, 0, 8'h00, 0, 1, 8'h00, 0, 8'h00, 0, 0, 8'h00);
        vt[5]  = mk(1, 1, 8'h44, 0, 1, 8'h03, 0, 8'h44, 0, 0, 8'h00);
        vt[6]  = mk(0, 1, 8'hFE, 0, 1, 8'h00, 1, 8'hFE, 0, 0, 8'h00);
        vt[7]  = mk(0, 1, 8'hFD, 0, 1, 8'h01, 1, 8'hFD, 0, 0, 8'h00);
        vt[8]  = mk(0, 1, 8'hFF, 0, 1, 8'h02, 1, 8'hFF, 0, 0, 8'h00);
        vt[9]  = mk(0, 1, 8'h99, 1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00);
        vt[10] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 1, 0, 8'h00);
        vt[11] = mk(0, 0, 8'h00, 1, 0, 8'h01, 0, 8'h00, 1, 0, 8'h00);
        vt[12] = mk(0, 0, 8'h00, 0, 0, 8'h02, 0, 8'h00, 1, 0, 8'h00);
        vt[13] = mk(0, 0, 8'h00, 0, 0, 8'hFE, 0, 8'h00, 1, 0, 8'h00);
        vt[14] = mk(0, 0, 8'h00, 0, 0, 8'hFD, 0, 8'h00, 1, 0, 8'h00);
        vt[15] = mk(0, 0, 8'h00, 0, 0, 8'hFE, 1, 8'hFB, 1, 0, 8'h00);
        vt[16] = mk(0, 1, 8'h77, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'hFF);
        vt[17] = mk(0, 0, 8'h00, 0, 0, 8'h00, 0, 8'h00, 0, 1, 8'hFF);

        step();
        step();

        // Load, reset-with-load, program load, start timing, halt.
        for (int i = 0; i < 18; i++) begin
            rst            = vt[i].rst;
            bus.load_valid = vt[i].lv;
            bus.load_data  = vt[i].ld;
            start          = vt[i].st;
            @(negedge clk);
            check($sformatf("v%0d load_ready", i), {15'h0, bus.load_ready}, {15'h0, vt[i].rdy});
            check($sformatf("v%0d mem_addr", i), {8'h0, bus.mem_addr}, {8'h0, vt[i].addr});
            check($sformatf("v%0d mem_wr_en", i), {15'h0, bus.mem_wr_en}, {15'h0, vt[i].we});
            check($sformatf("v%0d mem_wdata", i), {8'h0, bus.mem_wdata}, {8'h0, vt[i].wd});
            check($sformatf("v%0d running", i), {15'h0, running}, {15'h0, vt[i].run});
            check($sformatf("v%0d halted", i), {15'h0, halted}, {15'h0, vt[i].hlt});
            check($sformatf("v%0d pc", i), {8'h0, pc}, {8'h0, vt[i].pc});
            step();
        end
        rst = 1'b0; bus.load_valid = 1'b0; start = 1'b0;
        check("out_port", {8'h0, uo_out}, 16'h00FB);
        check("ram0", {8'h0, ram[0]}, 16'h00FE);
        check("ram2", {8'h0, ram[2]}, 16'h00FF);
        check("ram3_untouched", {8'h0, ram[3]}, 16'h0000);

        // Three-instruction program: not taken, zero-result taken, halt.
        for (int i = 0; i < 25; i++) prog[i] = 8'h00;
        prog[0] = 8'd20; prog[1] = 8'd21; prog[2] = 8'd0;
        prog[3] = 8'd22; prog[4] = 8'd23; prog[5] = 8'd9;
        prog[9] = 8'd24; prog[10] = 8'd24; prog[11] = 8'd255;
        prog[20] = 8'd7; prog[21] = 8'd3; prog[22] = 8'd3; prog[23] = 8'd3; prog[24] = 8'd5;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = prog[i];
            step();
        end
        bus.load_valid = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        run_instr(8'd0, 8'd20, 8'd21, 8'h04, 8'd3);
        run_instr(8'd3, 8'd22, 8'd23, 8'h00, 8'd9);
        run_instr(8'd9, 8'd24, 8'd24, 8'h00, 8'hFF);
        check("prog halted", {15'h0, halted}, 16'h1);
        check("prog not running", {15'h0, running}, 16'h0);
        check("ram20", {8'h0, ram[20]}, 16'h0004);
        check("ram22", {8'h0, ram[22]}, 16'h0000);

        // Restart from HALT with RAM preserved: mem[20] is now 4, so 4-3 = 1.
        start = 1'b1;
        step();
        start = 1'b0;
        run_instr(8'd0, 8'd20, 8'd21, 8'h01, 8'd3);

        // Reset during READ_B of the next instruction aborts before its write.
        for (int k = 0; k < 4; k++) step();
        rst = 1'b1;
        wr_base = wr_count;
        @(negedge clk);
        check("abort readb addr", {8'h0, bus.mem_addr}, 16'd23);
        check("abort readb we", {15'h0, bus.mem_wr_en}, 16'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        check("abort we", {15'h0, bus.mem_wr_en}, 16'h0);
        check("abort pc", {8'h0, pc}, 16'h0);
        check("abort running", {15'h0, running}, 16'h0);
        check("abort halted", {15'h0, halted}, 16'h0);
        check("abort load_ready", {15'h0, bus.load_ready}, 16'h1);
        step();
        check("abort no write", wr_count[15:0], wr_base[15:0]);
        check("abort ram22", {8'h0, ram[22]}, 16'h0000);

        // Overflow: 260 bytes offered back-to-back from a cleared load pointer.
        rst = 1'b1;
        step();
        rst = 1'b0;
        wr_base = wr_count;
        for (int i = 0; i < 260; i++) begin
            bus.load_valid = 1'b1;
            bus.load_data  = 8'(i);
            @(negedge clk);
            check($sformatf("ovf%0d ready", i), {15'h0, bus.load_ready}, {15'h0, (i < 253)});
            if (i < 253) check($sformatf("ovf%0d addr", i), {8'h0, bus.mem_addr}, 16'(i));
            step();
        end
        bus.load_valid = 1'b0;
        step();
        check("ovf write count", 16'(wr_count - wr_base), 16'd253);
        check("ovf ram252", {8'h0, ram[252]}, 16'd252);
        check("ovf ram100", {8'h0, ram[100]}, 16'd100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sic1_sequencer.md
# sic1_sequencer

Execution controller for the SIC-1 subleq core: the only master of the single-port byte memory (253 RAM bytes, input port at 253, output port at 254). It loads a program byte-serially into RAM from address 0, then runs subleq instructions by issuing one memory access per cycle until a branch targets address 255. Memory reads are combinational on the address; memory writes commit on the clock edge.

## Interface

- No parameters. Fixed constants: ADDR_LOAD_MAX = 252, ADDR_HALT = 255.

- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- start  input  1  pulse: begin execution at pc = 0 (accepted in IDLE or HALT)
- load_valid  input  1  program byte present on load_data
- load_data  input  8  program byte
- load_ready  output  1  load byte accepted this cycle if load_valid
- mem_addr  output  8  memory address (combinational from state/registers)
- mem_wr_en  output  1  memory write enable
- mem_wdata  output  8  memory write data
- mem_rdata  input  8  memory read data (combinational from mem_addr)
- pc  output  8  current instruction address
- running  output  1  high in any execute state
- halted  output  1  high in HALT

## Operation

- States: IDLE, FETCH_A, FETCH_B, FETCH_C, READ_A, READ_B, WRITE, HALT.
- Reset: state IDLE, pc 0, load_ptr 0, a/b/c/va/vb 0; outputs mem_addr 0, mem_wr_en 0, mem_wdata 0, running 0, halted 0, load_ready 1. mem_wr_en forced 0 during any cycle with rst high.
- IDLE: load_ready = (load_ptr <= 252). If load_valid && load_ready: mem_addr = load_ptr, mem_wdata = load_data, mem_wr_en = 1, load_ptr += 1. Bytes offered with load_ptr > 252 are dropped (load_ready 0). Otherwise mem_addr = 0, mem_wr_en = 0.
- start in IDLE: pc <= 0, next FETCH_A; a load offered in the same cycle is not accepted (load_ready 0 when start high). load_ready 0 outside IDLE.
- FETCH_A: mem_addr = pc, a <= mem_rdata. FETCH_B: mem_addr = pc+1, b <= mem_rdata. FETCH_C: mem_addr = pc+2, c <= mem_rdata. All pc offsets mod 256.
- READ_A: mem_addr = a, va <= mem_rdata. READ_B: mem_addr = b, vb <= mem_rdata (address 253 yields the input port, 254/255 yield 0 — memory behaviour, not special-cased here).
- WRITE: r = (va - vb) mod 256; mem_addr = a, mem_wdata = r, mem_wr_en = 1. Branch taken if r == 0 or r[7] == 1 (signed ≤ 0): next_pc = c, else next_pc = pc + 3 mod 256. pc <= next_pc. If next_pc == 255: next HALT, else FETCH_A.
- Write to address 253 or 255 is still issued (memory ignores it); write to 254 drives output port.
- HALT: mem_wr_en 0, mem_addr 0, pc holds 255. start: pc <= 0, next FETCH_A (RAM contents and load_ptr retained). load_valid ignored.
- start outside IDLE/HALT ignored. Only rst returns to IDLE / reopens loading; rst mid-instruction aborts with no write and load_ptr cleared to 0.

## Timing

- start sampled high at edge N → FETCH_A during cycle N+1; WRITE during cycle N+6.
- Every instruction: exactly 6 cycles, one memory access per cycle, no idle cycles between instructions.
- Halting instruction: write in cycle k, halted = 1 and running = 0 from cycle k+1.
- Load: one byte per cycle at full rate; 253 bytes max.
- running = 1 in FETCH_A..WRITE; running and halted never both 1.

## Test plan

- Load 0x11,0x22,0x33 with load_valid held 3 cycles → writes at addresses 0,1,2 on consecutive cycles, load_ptr 3, no extra writes.
- Program 254,253,255; ui_in = 5; start → cycles +1..+6 addresses 0,1,2,254,253,254; WRITE data 0xFB to 254; halted next cycle, pc 255.
- Branch not taken: mem[10]=7, mem[11]=3, program 10,11,0 → write 0x04 to 10, pc = 3, FETCH_A at address 3.
- Zero result: mem[10]=3, mem[11]=3, program 10,11,6 → write 0x00, pc = 6 (taken).
- Offer 260 bytes continuously → exactly 253 writes (addresses 0..252), load_ready low from byte 254 onward.
- Assert rst during READ_B → no write issued, state IDLE, pc 0, load_ready 1; start after halt → restarts at pc 0 with RAM preserved.
